// File: rtl/pw_lockout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pw_lockout_ctrl : attempt limiter that pulses the password FSM, samples    |
// |                   its verdict and enforces a timed lockout after failures. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pw_lockout_ctrl #(
   parameter int MAX_FAIL       = 3,
   parameter int RESULT_DLY     = 4,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int LOCK_W         = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter_in,
   input  logic       fsm_open,
   output logic       fsm_enter,
   output logic       fsm_clear,
   output logic       open,
   output logic       locked_out,
   output logic [3:0] fail_cnt
);

   localparam int DLY_W = (RESULT_DLY > 1) ? $clog2(RESULT_DLY + 1) : 1;
   localparam logic [DLY_W-1:0]  c_dly_load  = DLY_W'(RESULT_DLY);
   localparam logic [LOCK_W-1:0] c_lock_load = LOCK_W'(LOCKOUT_CYCLES);
   localparam logic [3:0]        c_max_fail  = 4'(MAX_FAIL);
   localparam logic [3:0]        c_fail_sat  = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PULSE    = 3'd1,
      S_WAIT     = 3'd2,
      S_UNLOCKED = 3'd3,
      S_LOCKOUT  = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_sync1, r_sync2, r_hist;
   logic [DLY_W-1:0]  r_dly, w_dly_nxt;
   logic [LOCK_W-1:0] r_timer, w_timer_nxt;
   logic [3:0]        r_fail, w_fail_nxt, w_fail_inc;
   logic              r_open, w_open_nxt;
   logic              r_locked, w_locked_nxt;
   logic              r_clear, w_clear_nxt;
   logic              w_rise;

   assign w_rise     = r_sync2 & ~r_hist;
   assign w_fail_inc = (r_fail == c_fail_sat) ? c_fail_sat : r_fail + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hist   <= 1'b0;
         r_dly    <= '0;
         r_timer  <= '0;
         r_fail   <= 4'd0;
         r_open   <= 1'b0;
         r_locked <= 1'b0;
         r_clear  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sync1  <= enter_in;
         r_sync2  <= r_sync1;
         r_hist   <= r_sync2;
         r_dly    <= w_dly_nxt;
         r_timer  <= w_timer_nxt;
         r_fail   <= w_fail_nxt;
         r_open   <= w_open_nxt;
         r_locked <= w_locked_nxt;
         r_clear  <= w_clear_nxt;
      end
   end

   // Rise events outside IDLE are simply never consumed, so they are dropped.
   always_comb begin
      w_state_nxt  = r_state;
      w_dly_nxt    = r_dly;
      w_timer_nxt  = r_timer;
      w_fail_nxt   = r_fail;
      w_open_nxt   = r_open;
      w_locked_nxt = r_locked;
      w_clear_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) w_state_nxt = S_PULSE;
         end
         S_PULSE: begin
            w_dly_nxt   = c_dly_load;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_dly == DLY_W'(1)) begin
               if (fsm_open) begin
                  w_state_nxt = S_UNLOCKED;
                  w_fail_nxt  = 4'd0;
                  w_open_nxt  = 1'b1;
               end else begin
                  w_fail_nxt  = w_fail_inc;
                  w_clear_nxt = 1'b1;
                  if (w_fail_inc >= c_max_fail) begin
                     w_state_nxt  = S_LOCKOUT;
                     w_timer_nxt  = c_lock_load;
                     w_locked_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end else begin
               w_dly_nxt = r_dly - DLY_W'(1);
            end
         end
         S_UNLOCKED: begin
            if (!fsm_open) begin
               w_open_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (r_timer == LOCK_W'(1)) begin
               w_state_nxt  = S_IDLE;
               w_fail_nxt   = 4'd0;
               w_locked_nxt = 1'b0;
            end else begin
               w_timer_nxt = r_timer - LOCK_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign fsm_enter  = (r_state == S_PULSE);
   assign fsm_clear  = r_clear;
   assign open       = r_open;
   assign locked_out = r_locked;
   assign fail_cnt   = r_fail;

endmodule
`default_nettype wire
